vector_load_unit: RTL and testbench
===================================

VECTOR_LOAD_UNIT -- requirements
Module: vector_load_unit

Interface
REQ-001 Parameter N_WORDS, default 8, number of 32-bit words per vector.
REQ-002 Parameter WORD_W, default 32, memory data word width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  load request, sampled only in IDLE.
REQ-006 base_addr  input  32  byte address of vector word 0, sampled with start.
REQ-007 rd  input  5  destination vector register, sampled with start.
REQ-008 mem_rd_en  output  1  memory read strobe.
REQ-009 mem_addr  output  32  memory byte address.
REQ-010 mem_rdata  input  32  memory read data, valid exactly 1 cycle after its mem_rd_en cycle.
REQ-011 WriteEn  output  1  register-file write enable, a 1-cycle pulse.
REQ-012 rd_out  output  5  register-file destination address.
REQ-013 InputData  output  256  assembled vector to the register file.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  1-cycle completion pulse, coincident with WriteEn.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, DRAIN and WRITE.
REQ-017 IDLE with start=1 SHALL latch base_addr with bits [1:0] forced to 0, latch rd, clear the word counter and go to READ.
REQ-018 READ SHALL assert mem_rd_en with mem_addr = base + 4*k for k = 0..N_WORDS-1 on consecutive cycles, and go to DRAIN after k = N_WORDS-1.
REQ-019 Address arithmetic SHALL be modulo 2^32 (wrap-around past 0xFFFFFFFC, no error).
REQ-020 Each cycle after a mem_rd_en cycle for word k, mem_rdata SHALL be captured into vector bits [32k+31:32k].
REQ-021 DRAIN SHALL capture the last word with mem_rd_en=0 and then go to WRITE.
REQ-022 WRITE SHALL assert WriteEn=1 and done=1 for exactly one cycle, with rd_out = latched rd and InputData = the full assembled vector, and then go to IDLE.
REQ-023 Latency SHALL be 10 cycles from the start-accept edge to the WriteEn cycle: 8 READ cycles, 1 DRAIN cycle, then WRITE.
REQ-024 start while busy=1 SHALL be ignored (no queuing), and the latched operands SHALL NOT change.
REQ-025 start asserted in the WRITE cycle SHALL be ignored; a new load requires start in IDLE.
REQ-026 When WriteEn=0, mem_addr SHALL hold its last value, while InputData and rd_out hold the last completed load.
REQ-027 mem_rd_en and WriteEn SHALL never be high in the same cycle.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, busy=0, done=0, WriteEn=0, mem_rd_en=0, mem_addr=0, rd_out=0, InputData=0 and counter=0.
REQ-029 rst during READ or DRAIN SHALL abort the load with no WriteEn pulse, and the partial vector SHALL be discarded (cleared).
REQ-030 Following rst deassertion, the first start SHALL be accepted on the next clk edge in IDLE.

Structure
REQ-031 The shared package vlu_pkg SHALL hold the state enum (IDLE, READ, DRAIN, WRITE), VEC_W=256, WORD_W=32, N_WORDS=8 and REG_ADDR_W=5.
REQ-032 The natural sub-module is vlu_word_collector: a counter-indexed 256-bit capture register with clear and word-write; everything else SHALL be flat in vector_load_unit.
REQ-033 The outputs rd_out, InputData and WriteEn SHALL connect directly to the vector register-file write port (rd, InputData, WriteEn) with no added stage.

Verification
REQ-034 Basic load: start with base=0x100 and rd=3, memory word i = 0x11111111*(i+1) -> mem_addr steps 0x100..0x11C; 10 cycles later WriteEn=1, rd_out=3, InputData[31:0]=0x11111111 and InputData[255:224]=0x88888888.
REQ-035 Misaligned base: base=0x203 -> first mem_addr=0x200 and the result is identical to base=0x200.
REQ-036 Wrap: base=0xFFFFFFF0 -> addresses 0xFFFFFFF0..0xFFFFFFFC, then 0x0..0xC; word 4 is read from 0x0.
REQ-037 Busy start: second start with rd=7 at READ cycle 3 -> ignored; one WriteEn with rd_out=first rd; busy stays continuous.
REQ-038 Reset mid-load: rst at DRAIN -> no WriteEn; all outputs 0; a fresh load afterwards completes correctly in 10 cycles.
REQ-039 Back-to-back: start held high -> loads complete every 11 cycles (WRITE to IDLE to accept) with no WriteEn overlap.

Source files
------------

// File: rtl/vlu_pkg.sv
// Shared definitions for the vector load unit.
//   state_t    : load FSM states (IDLE, READ, DRAIN, WRITE)
//   VEC_W      : assembled vector width in bits
//   WORD_W     : memory word width in bits
//   N_WORDS    : words per vector
//   REG_ADDR_W : vector register-file address width
package vlu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int VEC_W      = 256;
  localparam int WORD_W     = 32;
  localparam int N_WORDS    = 8;
  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/vlu_word_collector.sv
// Counter-indexed vector capture register.
//   clk, rst   : clock, asynchronous active-high reset (clears the vector)
//   clear      : synchronous clear of the whole vector
//   word_en    : write word_data into slot word_idx
//   word_idx   : destination word slot
//   word_data  : incoming memory word
//   vec        : registered vector contents
//   vec_next   : vector contents with this cycle's write already applied
module vlu_word_collector #(
  parameter int N_WORDS = vlu_pkg::N_WORDS,
  parameter int WORD_W  = vlu_pkg::WORD_W,
  parameter int IDX_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      word_en,
  input  logic [IDX_W-1:0]          word_idx,
  input  logic [WORD_W-1:0]         word_data,
  output logic [N_WORDS*WORD_W-1:0] vec,
  output logic [N_WORDS*WORD_W-1:0] vec_next
);

  always_comb begin
    vec_next = vec;
    if (word_en) vec_next[word_idx*WORD_W +: WORD_W] = word_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        vec <= '0;
    else if (clear) vec <= '0;
    else            vec <= vec_next;
  end

endmodule

// File: rtl/vector_load_unit.sv
// Vector load unit: reads N_WORDS consecutive memory words and writes the
// assembled vector to the vector register file in one pulse.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : load request (only honoured in IDLE)
//   base_addr, rd     : byte address of word 0 and destination register
//   mem_rd_en         : memory read strobe
//   mem_addr          : memory byte address (holds after the last read)
//   mem_rdata         : read data, valid the cycle after mem_rd_en
//   WriteEn, rd_out,
//   InputData         : register-file write port (held between loads)
//   busy, done        : not-idle flag, completion pulse with WriteEn
module vector_load_unit #(
  parameter int N_WORDS = vlu_pkg::N_WORDS,
  parameter int WORD_W  = vlu_pkg::WORD_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [31:0]                     base_addr,
  input  logic [vlu_pkg::REG_ADDR_W-1:0]  rd,
  output logic                            mem_rd_en,
  output logic [31:0]                     mem_addr,
  input  logic [WORD_W-1:0]               mem_rdata,
  output logic                            WriteEn,
  output logic [vlu_pkg::REG_ADDR_W-1:0]  rd_out,
  output logic [N_WORDS*WORD_W-1:0]       InputData,
  output logic                            busy,
  output logic                            done
);
  import vlu_pkg::*;

  localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_WORDS - 1);

  state_t                    state, state_next;
  logic [CNT_W-1:0]          cnt;
  logic [REG_ADDR_W-1:0]     rd_q;
  logic                      accept;
  logic                      word_en;
  logic [CNT_W-1:0]          word_idx;
  logic [N_WORDS*WORD_W-1:0] vec;
  logic [N_WORDS*WORD_W-1:0] vec_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Data for the read issued in the previous cycle arrives now, so the
  // capture slot trails the read counter by one word.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    word_en    = 1'b0;
    word_idx   = cnt - CNT_W'(1);
    mem_rd_en  = 1'b0;
    WriteEn    = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        mem_rd_en = 1'b1;
        word_en   = (cnt != '0);
        if (cnt == LAST) state_next = DRAIN;
      end
      DRAIN: begin
        word_en    = 1'b1;
        word_idx   = LAST;
        state_next = WRITE;
      end
      WRITE: begin
        WriteEn    = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  vlu_word_collector #(
    .N_WORDS (N_WORDS),
    .WORD_W  (WORD_W),
    .IDX_W   (CNT_W)
  ) u_collector (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .word_en   (word_en),
    .word_idx  (word_idx),
    .word_data (mem_rdata),
    .vec       (vec),
    .vec_next  (vec_next)
  );

  // The output copy is taken from vec_next in DRAIN so the write port sees
  // the complete vector in WRITE while holding the previous result during
  // the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rd_q      <= '0;
      mem_addr  <= '0;
      rd_out    <= '0;
      InputData <= '0;
    end else begin
      if (accept) begin
        cnt      <= '0;
        rd_q     <= rd;
        mem_addr <= base_addr & 32'hFFFF_FFFC;
      end
      if (state == READ) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt != LAST) mem_addr <= mem_addr + 32'd4;
      end
      if (state == DRAIN) begin
        rd_out    <= rd_q;
        InputData <= vec_next;
      end
    end
  end

endmodule

// File: tb/tb_vector_load_unit.sv
// Self-checking bench for vector_load_unit: directed cases plus random loads
// against a behavioural memory/vector model.
module tb_vector_load_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [4:0]   rd;
  logic         mem_rd_en;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata = '0;
  logic         WriteEn;
  logic [4:0]   rd_out;
  logic [255:0] InputData;
  logic         busy;
  logic         done;

  int err_cnt = 0;
  int chk_cnt = 0;
  int we_cnt  = 0;

  int          pat_mode = 0;
  logic [31:0] pat_seed = 32'h5A5A_1234;

  logic [255:0] last_vec  = '0;
  logic [4:0]   last_rd   = '0;
  logic [31:0]  last_addr = '0;

  vector_load_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .rd        (rd),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .WriteEn   (WriteEn),
    .rd_out    (rd_out),
    .InputData (InputData),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (pat_mode == 0) return 32'h1111_1111 * (((a - 32'h100) >> 2) + 32'd1);
    return (a * 32'h9E37_79B1) ^ pat_seed;
  endfunction

  // Memory answers one cycle after each read strobe.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_word(mem_addr);

  always @(negedge clk) if (WriteEn) we_cnt++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge with the unit idle. Returns at the negedge of the
  // WRITE cycle. inj_c > 0 drives a stray start (rd=7) during that cycle.
  task automatic run_load(input logic [31:0] b, input logic [4:0] r,
                          input bit hold_start, input int inj_c, input string name);
    logic [255:0] exp_vec;
    logic [31:0]  a0, exp_addr;
    a0 = b & 32'hFFFF_FFFC;
    for (int i = 0; i < 8; i++) exp_vec[32*i +: 32] = mem_word(a0 + 32'(4*i));
    check({name, " idle_ctrl"}, {busy, WriteEn, mem_rd_en, mem_addr, rd_out},
          {3'b000, last_addr, last_rd});
    check({name, " idle_data"}, InputData, last_vec);
    start = 1'b1; base_addr = b; rd = r;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (inj_c > 0 && c == inj_c) begin start = 1'b1; rd = 5'd7; base_addr = ~b; end
      if (inj_c > 0 && c == inj_c + 1) start = 1'b0;
      exp_addr = (c <= 8) ? a0 + 32'(4*(c-1)) : a0 + 32'd28;
      check($sformatf("%s c%0d ctrl", name, c), {busy, mem_rd_en, WriteEn, done, mem_addr},
            {1'b1, (c <= 8), (c == 10), (c == 10), exp_addr});
      check($sformatf("%s c%0d data", name, c), InputData, (c == 10) ? exp_vec : last_vec);
      check($sformatf("%s c%0d rd_out", name, c), rd_out, (c == 10) ? r : last_rd);
    end
    last_vec  = exp_vec;
    last_rd   = r;
    last_addr = a0 + 32'd28;
  endtask

  initial begin
    int we_before;
    rst = 1'b1; start = 1'b0; base_addr = '0; rd = '0;
    repeat (2) @(negedge clk);
    check("reset ctrl", {busy, done, WriteEn, mem_rd_en, mem_addr, rd_out}, '0);
    check("reset data", InputData, '0);
    rst = 1'b0;

    // Basic load
    pat_mode = 0;
    run_load(32'h100, 5'd3, 1'b0, 0, "basic");
    check("basic word0", InputData[31:0], 32'h1111_1111);
    check("basic word7", InputData[255:224], 32'h8888_8888);
    @(negedge clk);

    // Misaligned base behaves as aligned
    run_load(32'h203, 5'd9, 1'b0, 0, "misalign");
    repeat (2) @(negedge clk);

    // Address wrap-around
    pat_mode = 1;
    run_load(32'hFFFF_FFF0, 5'd12, 1'b0, 0, "wrap");
    check("wrap word4", InputData[159:128], mem_word(32'h0));
    @(negedge clk);

    // Start while busy is ignored
    we_before = we_cnt;
    run_load(32'h4000, 5'd3, 1'b0, 4, "busystart");
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("busystart no_queue", {busy, mem_rd_en}, 2'b00);
      @(negedge clk);
    end
    check("busystart one_pulse", 32'(we_cnt - we_before), 32'd1);

    // Reset at DRAIN aborts the load
    we_before = we_cnt;
    start = 1'b1; base_addr = 32'h8000; rd = 5'd21;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    check("abort drain", {busy, mem_rd_en, WriteEn}, 3'b100);
    rst = 1'b1;
    #1;
    check("abort ctrl", {busy, done, WriteEn, mem_rd_en, mem_addr, rd_out}, '0);
    check("abort data", InputData, '0);
    @(negedge clk);
    rst = 1'b0;
    check("abort no_we", 32'(we_cnt - we_before), 32'd0);
    last_vec = '0; last_rd = '0; last_addr = '0;
    run_load(32'h8000, 5'd21, 1'b0, 0, "after_rst");
    @(negedge clk);

    // Back-to-back with start held high
    we_before = we_cnt;
    run_load(32'h1000, 5'd1, 1'b1, 0, "b2b0");
    @(negedge clk);
    run_load(32'h2004, 5'd2, 1'b1, 0, "b2b1");
    @(negedge clk);
    run_load(32'h3008, 5'd30, 1'b0, 0, "b2b2");
    @(negedge clk);
    check("b2b pulses", 32'(we_cnt - we_before), 32'd3);

    // Random loads
    for (int n = 0; n < 8; n++) begin
      pat_seed = $urandom;
      run_load($urandom, 5'($urandom_range(0, 31)), 1'b0, 0, $sformatf("rand%0d", n));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
